// File: rtl/padd_sat_pipe_pkg.sv
// Shared definitions for the packed saturating add/sub pipeline:
// operation encodings and per-lane saturation bound patterns.
package padd_pkg;

  typedef enum logic [1:0] {
    OP_SADD = 2'b00,
    OP_SSUB = 2'b01,
    OP_UADD = 2'b10,
    OP_USUB = 2'b11
  } op_e;

  localparam int MAX_LANE_W = 32;

  // Bound patterns for a w-bit lane, right-aligned in a MAX_LANE_W vector.
  function automatic logic [MAX_LANE_W-1:0] lane_smax(input int w);
    return (MAX_LANE_W'(1) << (w - 1)) - MAX_LANE_W'(1);
  endfunction

  function automatic logic [MAX_LANE_W-1:0] lane_smin(input int w);
    return MAX_LANE_W'(1) << (w - 1);
  endfunction

  function automatic logic [MAX_LANE_W-1:0] lane_umax(input int w);
    return (MAX_LANE_W'(1) << w) - MAX_LANE_W'(1);
  endfunction

endpackage

// File: rtl/padd_sat_pipe_sat_lane.sv
// One lane of the saturating adder: raw (LANE_W+1)-bit sum/difference on the
// S1 side, saturation select on the registered raw value on the S2 side.
module sat_lane import padd_pkg::*; #(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  input  logic [1:0]        i_op,
  output logic [LANE_W:0]   o_raw,
  input  logic [LANE_W:0]   i_raw,
  input  logic [1:0]        i_op_q,
  output logic [LANE_W-1:0] o_res,
  output logic              o_sat
);

  localparam logic [LANE_W-1:0] SMAX = LANE_W'(lane_smax(LANE_W));
  localparam logic [LANE_W-1:0] SMIN = LANE_W'(lane_smin(LANE_W));
  localparam logic [LANE_W-1:0] UMAX = LANE_W'(lane_umax(LANE_W));

  logic [LANE_W:0] w_a_ext;
  logic [LANE_W:0] w_b_ext;

  // Sign- or zero-extension makes the extra bit exact: it is the carry/borrow
  // for unsigned ops and disagrees with the lane MSB on signed overflow.
  assign w_a_ext = {(i_op[1] ? 1'b0 : i_a[LANE_W-1]), i_a};
  assign w_b_ext = {(i_op[1] ? 1'b0 : i_b[LANE_W-1]), i_b};
  assign o_raw   = i_op[0] ? (w_a_ext + ~w_b_ext + (LANE_W+1)'(1))
                           : (w_a_ext + w_b_ext);

  always_comb begin
    o_res = i_raw[LANE_W-1:0];
    o_sat = 1'b0;
    if (i_op_q[1]) begin
      if (i_raw[LANE_W]) begin
        o_sat = 1'b1;
        o_res = i_op_q[0] ? '0 : UMAX;
      end
    end else if (i_raw[LANE_W] != i_raw[LANE_W-1]) begin
      o_sat = 1'b1;
      o_res = i_raw[LANE_W] ? SMIN : SMAX;
    end
  end

endmodule

// File: rtl/padd_sat_pipe.sv
// Two-stage packed-SIMD saturating add/sub unit with valid/ready handshake
// and a sticky saturation flag.
module padd_sat_pipe import padd_pkg::*; #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [LANE_W*LANES-1:0] i_a,
  input  logic [LANE_W*LANES-1:0] i_b,
  input  logic [1:0]              i_op,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [LANE_W*LANES-1:0] o_s,
  output logic [LANES-1:0]        o_sat_lanes,
  output logic                    o_sticky_sat,
  input  logic                    i_clr_sticky
);

  localparam int RAW_W = LANE_W + 1;

  logic                    w_en;
  logic [LANES*RAW_W-1:0]  w_raw;
  logic [LANE_W*LANES-1:0] w_res;
  logic [LANES-1:0]        w_sat;

  logic                    r_v1;
  logic [LANES*RAW_W-1:0]  r_raw;
  op_e                     r_op;
  logic                    r_ov;
  logic [LANE_W*LANES-1:0] r_s;
  logic [LANES-1:0]        r_sat;
  logic                    r_sticky;

  assign w_en         = ~r_ov | i_out_ready;
  assign o_in_ready   = w_en;
  assign o_out_valid  = r_ov;
  assign o_s          = r_s;
  assign o_sat_lanes  = r_sat;
  assign o_sticky_sat = r_sticky;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_lane #(.LANE_W(LANE_W)) u_lane (
      .i_a    (i_a[g*LANE_W +: LANE_W]),
      .i_b    (i_b[g*LANE_W +: LANE_W]),
      .i_op   (i_op),
      .o_raw  (w_raw[g*RAW_W +: RAW_W]),
      .i_raw  (r_raw[g*RAW_W +: RAW_W]),
      .i_op_q (r_op),
      .o_res  (w_res[g*LANE_W +: LANE_W]),
      .o_sat  (w_sat[g])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v1     <= 1'b0;
      r_raw    <= '0;
      r_op     <= OP_SADD;
      r_ov     <= 1'b0;
      r_s      <= '0;
      r_sat    <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_en) begin
        r_v1 <= i_in_valid;
        if (i_in_valid) begin
          r_raw <= w_raw;
          r_op  <= op_e'(i_op);
        end
        r_ov <= r_v1;
        if (r_v1) begin
          r_s   <= w_res;
          r_sat <= w_sat;
        end
      end
      // A saturating transfer in the same cycle as a clear keeps the flag set.
      if (r_ov && i_out_ready && (|r_sat))
        r_sticky <= 1'b1;
      else if (i_clr_sticky)
        r_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_padd_sat_pipe.sv
// Self-checking bench: directed cases plus randomized streaming against an
// arithmetic reference model with an in-order scoreboard.
module tb_padd_sat_pipe;
  import padd_pkg::*;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  sat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready, sticky, clr;
  logic [15:0] a, b, s;
  logic [1:0]  op;
  logic [3:0]  sat;

  logic        v8, rdy8, ov8, ordy8, sticky8, clr8;
  logic [15:0] a8, b8, s8;
  logic [1:0]  op8;
  logic [1:0]  sat8;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t q[$];
  logic  exp_sticky = 1'b0;

  always #5 clk = ~clk;

  padd_sat_pipe #(.LANE_W(4), .LANES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_op(op), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_s(s), .o_sat_lanes(sat), .o_sticky_sat(sticky), .i_clr_sticky(clr)
  );

  padd_sat_pipe #(.LANE_W(8), .LANES(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(v8), .o_in_ready(rdy8),
    .i_a(a8), .i_b(b8), .i_op(op8), .o_out_valid(ov8), .i_out_ready(ordy8),
    .o_s(s8), .o_sat_lanes(sat8), .o_sticky_sat(sticky8), .i_clr_sticky(clr8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane-by-lane integer arithmetic, clamped to the lane's representable range.
  function automatic beat_t model(input int lw, input int nl, input logic [15:0] ma,
                                  input logic [15:0] mb, input logic [1:0] mop);
    beat_t r;
    r.s   = '0;
    r.sat = '0;
    for (int i = 0; i < nl; i++) begin
      int ua, ub, sa, sb, v, lo, hi;
      ua = int'((ma >> (i*lw)) & 16'((1 << lw) - 1));
      ub = int'((mb >> (i*lw)) & 16'((1 << lw) - 1));
      sa = (ua >= (1 << (lw-1))) ? ua - (1 << lw) : ua;
      sb = (ub >= (1 << (lw-1))) ? ub - (1 << lw) : ub;
      if (mop[1]) begin
        lo = 0; hi = (1 << lw) - 1;
        v  = mop[0] ? ua - ub : ua + ub;
      end else begin
        lo = -(1 << (lw-1)); hi = (1 << (lw-1)) - 1;
        v  = mop[0] ? sa - sb : sa + sb;
      end
      if (v > hi) begin v = hi; r.sat[i] = 1'b1; end
      else if (v < lo) begin v = lo; r.sat[i] = 1'b1; end
      r.s = r.s | (16'(v & ((1 << lw) - 1)) << (i*lw));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_sticky = 1'b0;
    end else begin
      check("mon_in_ready", in_ready, !out_valid || out_ready);
      check("mon_sticky", sticky, exp_sticky);
      if (out_valid) begin
        if (q.size() == 0) check("mon_unexpected_beat", 1, 0);
        else begin
          check("mon_s", s, q[0].s);
          check("mon_sat", sat, q[0].sat);
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        if (|q[0].sat) exp_sticky = 1'b1;
        else if (clr) exp_sticky = 1'b0;
        void'(q.pop_front());
      end else if (clr) exp_sticky = 1'b0;
      if (in_valid && in_ready) q.push_back(model(4, 4, a, b, op));
    end
  end

  task automatic run_beat(input string tag, input logic [15:0] da, input logic [15:0] db,
                          input logic [1:0] dop, input logic [15:0] es, input logic [3:0] esat);
    clr = 1'b1; a = da; b = db; op = dop; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
    check({tag, "_ov_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_ov"}, out_valid, 1);
    check({tag, "_s"}, s, es);
    check({tag, "_sat"}, sat, esat);
    @(posedge clk); #1;
    check({tag, "_sticky"}, sticky, |esat);
    check({tag, "_ov_after"}, out_valid, 0);
  endtask

  initial begin
    beat_t e0, e1, e2;
    in_valid = 0; out_ready = 1; clr = 0; a = 0; b = 0; op = 0;
    v8 = 0; ordy8 = 1; clr8 = 0; a8 = 0; b8 = 0; op8 = 0;
    #12;
    check("rst_ov", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_sat", sat, 0);
    check("rst_sticky", sticky, 0);
    @(posedge clk); #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);

    run_beat("t1", 16'h7F18, 16'h1188, OP_SADD, 16'h7098, 4'b1001);
    run_beat("t2a", 16'h0305, 16'h0410, OP_USUB, 16'h0005, 4'b0110);
    run_beat("t2b", 16'hF001, 16'h200F, OP_UADD, 16'hF00F, 4'b1001);
    run_beat("t3", 16'h8070, 16'h1090, OP_SSUB, 16'h8070, 4'b1010);
    run_beat("t_nosat", 16'h1234, 16'h1111, OP_UADD, 16'h2345, 4'b0000);

    // Backpressure: three beats offered while the consumer stalls.
    e0 = model(4, 4, 16'h7F18, 16'h1188, OP_SADD);
    e1 = model(4, 4, 16'h1234, 16'h4321, OP_USUB);
    e2 = model(4, 4, 16'h8888, 16'h7777, OP_SSUB);
    out_ready = 0; in_valid = 1; a = 16'h7F18; b = 16'h1188; op = OP_SADD;
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h4321; op = OP_USUB;
    @(posedge clk); #1;
    check("bp_in_ready", in_ready, 0);
    a = 16'h8888; b = 16'h7777; op = OP_SSUB;
    @(posedge clk); #1;
    check("bp_hold_s", s, e0.s);
    check("bp_hold_sat", sat, e0.sat);
    @(posedge clk); #1;
    check("bp_hold_s2", s, e0.s);
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("bp_beat1", s, e1.s);
    @(posedge clk); #1;
    check("bp_beat2_ov", out_valid, 1);
    check("bp_beat2", s, e2.s);
    @(posedge clk); #1;
    check("bp_drained", out_valid, 0);

    // Sticky: clear coinciding with a saturating transfer, then a plain clear.
    clr = 1; a = 16'h7F18; b = 16'h1188; op = OP_SADD; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sticky_set_wins", sticky, 1);
    @(posedge clk); #1;
    check("sticky_cleared", sticky, 0);
    clr = 0;

    // Reset with two beats in flight, sticky previously set.
    run_beat("t1_again", 16'h7F18, 16'h1188, OP_SADD, 16'h7098, 4'b1001);
    in_valid = 1; a = 16'h0123; b = 16'h0456; op = OP_UADD;
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h0101; op = OP_SADD;
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_s", s, 0);
    check("mid_rst_sticky", sticky, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale", out_valid, 0);
    end

    // Wide-lane configuration.
    a8 = 16'h7F80; b8 = 16'h01FF; op8 = OP_SADD; v8 = 1;
    @(posedge clk); #1 v8 = 0;
    @(posedge clk); #1;
    check("w8_ov", ov8, 1);
    check("w8_s", s8, 16'h7F80);
    check("w8_sat", sat8, 2'b11);
    @(posedge clk); #1;
    check("w8_sticky", sticky8, 1);
    check("w8_rdy", rdy8, 1);

    // Randomized streaming with random backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr       = ($urandom % 8) == 0;
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 2'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1; clr = 0;
    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
